// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS generator/checker pair: checker state
// encoding and the default feedback mask both ends must agree on.
package lfsr_pkg;

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    typedef enum logic [1:0] {
        ST_HUNT   = HUNT,
        ST_SYNC   = SYNC,
        ST_LOCKED = LOCKED
    } state_t;

    // x^16 + x^15 + x^13 + x^4 ; prediction is ^(sr & DEFAULT_TAPS)
    localparam logic [15:0] DEFAULT_TAPS = 16'hD008;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX = '1;

    // Count up on inc, stick at all-ones, clear takes priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != MAX)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/lfsr_seq_checker.sv
// PRBS sequence checker: self-seeds a local LFSR from the received stream,
// declares lock after a run of correct predictions, then free-runs the LFSR
// and counts bit errors, dropping lock when one window sees too many errors.
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int               NBITS     = 16,
    parameter logic [NBITS-1:0] TAPS      = NBITS'(DEFAULT_TAPS),
    parameter int               SYNC_LEN  = 32,
    parameter int               WIN       = 256,
    parameter int               LOSS_ERRS = 8,
    parameter int               CNTW      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            in_valid,
    input  logic            in_bit,
    output logic            locked,
    output logic            err_pulse,
    output logic [CNTW-1:0] err_count,
    output logic [CNTW-1:0] bit_count
);

    localparam int FILL_W = $clog2(NBITS + 1);
    localparam int RUN_W  = $clog2(SYNC_LEN + 1);
    localparam int WB_W   = $clog2(WIN + 1);
    localparam int WE_W   = $clog2(LOSS_ERRS + 1);

    state_t            state, state_nxt;
    logic [NBITS-1:0]  sr, sr_nxt;
    logic [FILL_W-1:0] fill, fill_nxt;
    logic [RUN_W-1:0]  run, run_nxt;
    logic [WB_W-1:0]   win_bits, win_bits_nxt;
    logic [WE_W-1:0]   win_errs, win_errs_nxt;
    logic              pred;
    logic              mismatch;
    logic              err_hit;
    logic              bit_hit;

    // Next-state, local LFSR update and per-bit error/count strobes
    always_comb begin
        pred         = ^(sr & TAPS);
        mismatch     = (in_bit != pred);
        state_nxt    = state;
        sr_nxt       = sr;
        fill_nxt     = fill;
        run_nxt      = run;
        win_bits_nxt = win_bits;
        win_errs_nxt = win_errs;
        err_hit      = 1'b0;
        bit_hit      = 1'b0;
        if (in_valid) begin
            unique case (state)
                ST_HUNT: begin
                    sr_nxt = {sr[NBITS-2:0], in_bit};
                    if (fill == FILL_W'(NBITS - 1)) begin
                        state_nxt = ST_SYNC;
                        fill_nxt  = '0;
                        run_nxt   = '0;
                    end else begin
                        fill_nxt = fill + FILL_W'(1);
                    end
                end
                ST_SYNC: begin
                    // keep seeding from the line; an all-zero register can never
                    // leave zero, so it is never allowed to count as a match
                    sr_nxt = {sr[NBITS-2:0], in_bit};
                    if (mismatch || (sr == '0)) begin
                        run_nxt = '0;
                    end else if (run == RUN_W'(SYNC_LEN - 1)) begin
                        state_nxt    = ST_LOCKED;
                        run_nxt      = '0;
                        win_bits_nxt = '0;
                        win_errs_nxt = '0;
                    end else begin
                        run_nxt = run + RUN_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // free-run on our own prediction so line errors do not
                    // propagate into the local copy
                    sr_nxt  = {sr[NBITS-2:0], pred};
                    bit_hit = 1'b1;
                    err_hit = mismatch;
                    if (mismatch && (win_errs == WE_W'(LOSS_ERRS - 1))) begin
                        state_nxt    = ST_HUNT;
                        fill_nxt     = '0;
                        win_bits_nxt = '0;
                        win_errs_nxt = '0;
                    end else if (win_bits == WB_W'(WIN - 1)) begin
                        win_bits_nxt = '0;
                        win_errs_nxt = '0;
                    end else begin
                        win_bits_nxt = win_bits + WB_W'(1);
                        win_errs_nxt = win_errs + WE_W'(mismatch);
                    end
                end
                default: begin
                    state_nxt = ST_HUNT;
                end
            endcase
        end
    end

    // State, LFSR copy, acquisition/window counters and error pulse register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_HUNT;
            sr        <= '0;
            fill      <= '0;
            run       <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            fill      <= fill_nxt;
            run       <= run_nxt;
            win_bits  <= win_bits_nxt;
            win_errs  <= win_errs_nxt;
            err_pulse <= err_hit;
        end
    end

    assign locked = (state == ST_LOCKED);

    sat_counter #(.W(CNTW)) u_err_count (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (err_hit),
        .q   (err_count)
    );

    sat_counter #(.W(CNTW)) u_bit_count (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (bit_hit),
        .q   (bit_count)
    );

endmodule
